// File: rtl/normalize_pipe_if.sv
// Handshake bundle for normalize_pipe: operand channel in, normalised result channel out.
// master = producer/consumer around the block, slave = the normaliser itself.
interface normalize_pipe_if #(
    parameter int WIDTH = 32,
    parameter int TAG_W = 5
);
    localparam int SHW = $clog2(WIDTH);

    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_data;
    logic             in_signed;
    logic [TAG_W-1:0] in_tag;

    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_data;
    logic [SHW-1:0]   out_shift;
    logic             out_zero;
    logic             out_sign;
    logic [TAG_W-1:0] out_tag;

    modport master (
        output in_valid, in_data, in_signed, in_tag, out_ready,
        input  in_ready, out_valid, out_data, out_shift, out_zero, out_sign, out_tag
    );

    modport slave (
        input  in_valid, in_data, in_signed, in_tag, out_ready,
        output in_ready, out_valid, out_data, out_shift, out_zero, out_sign, out_tag
    );
endinterface

// File: rtl/normalize_pipe.sv
// Pipelined leading-zero normaliser: stage 0 takes the magnitude, stages 1..SHW binary-search the shift.
// Define NORM_SIGNED_EN to honour in_signed (two's-complement negation in stage 0); otherwise unsigned only.
module normalize_pipe #(
    parameter int WIDTH = 32,
    parameter int TAG_W = 5
) (
    input  logic            clk,
    input  logic            rst,
    normalize_pipe_if.slave bus
);
    localparam int SHW = $clog2(WIDTH);

    logic [WIDTH-1:0] mag_q   [SHW+1];
    logic [SHW-1:0]   shift_q [SHW+1];
    logic             zero_q  [SHW+1];
    logic             sign_q  [SHW+1];
    logic [TAG_W-1:0] tag_q   [SHW+1];
    logic             valid_q [SHW+1];

    logic [WIDTH-1:0] mag_d   [SHW+1];
    logic [SHW-1:0]   shift_d [SHW+1];
    logic             zero_d  [SHW+1];
    logic             sign_d  [SHW+1];
    logic [TAG_W-1:0] tag_d   [SHW+1];
    logic             valid_d [SHW+1];

    logic             stall;
    logic             en;
    logic             neg;
    logic [WIDTH-1:0] mag_in;

    assign stall        = valid_q[SHW] & ~bus.out_ready;
    assign en           = ~stall;
    assign bus.in_ready = ~rst & ~stall;

`ifdef NORM_SIGNED_EN
    assign neg    = bus.in_signed & bus.in_data[WIDTH-1];
    // Most-negative input wraps to 2^(WIDTH-1), which is the correct unsigned magnitude.
    assign mag_in = neg ? (~bus.in_data + 1'b1) : bus.in_data;
`else
    logic unused_signed;
    assign unused_signed = bus.in_signed;
    assign neg           = 1'b0;
    assign mag_in        = bus.in_data;
`endif

    always_comb begin
        for (int i = 0; i <= SHW; i++) begin
            mag_d[i]   = '0;
            shift_d[i] = '0;
            zero_d[i]  = 1'b0;
            sign_d[i]  = 1'b0;
            tag_d[i]   = '0;
            valid_d[i] = 1'b0;
        end

        mag_d[0]   = mag_in;
        shift_d[0] = '0;
        zero_d[0]  = (mag_in == '0);
        sign_d[0]  = neg;
        tag_d[0]   = bus.in_tag;
        valid_d[0] = bus.in_valid;

        // Stage i tests the top 2^(SHW-i) bits; a zero field means shift by that amount.
        for (int i = 1; i <= SHW; i++) begin
            if ((mag_q[i-1] >> (WIDTH - (1 << (SHW - i)))) == '0) begin
                mag_d[i]   = mag_q[i-1] << (1 << (SHW - i));
                shift_d[i] = shift_q[i-1] | (SHW'(1) << (SHW - i));
            end else begin
                mag_d[i]   = mag_q[i-1];
                shift_d[i] = shift_q[i-1];
            end
            zero_d[i]  = zero_q[i-1];
            sign_d[i]  = sign_q[i-1];
            tag_d[i]   = tag_q[i-1];
            valid_d[i] = valid_q[i-1];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i <= SHW; i++) begin
                mag_q[i]   <= '0;
                shift_q[i] <= '0;
                zero_q[i]  <= 1'b0;
                sign_q[i]  <= 1'b0;
                tag_q[i]   <= '0;
                valid_q[i] <= 1'b0;
            end
        end else if (en) begin
            for (int i = 0; i <= SHW; i++) begin
                mag_q[i]   <= mag_d[i];
                shift_q[i] <= shift_d[i];
                zero_q[i]  <= zero_d[i];
                sign_q[i]  <= sign_d[i];
                tag_q[i]   <= tag_d[i];
                valid_q[i] <= valid_d[i];
            end
        end
    end

    assign bus.out_valid = valid_q[SHW];
    assign bus.out_data  = mag_q[SHW];
    assign bus.out_shift = shift_q[SHW];
    assign bus.out_zero  = zero_q[SHW];
    assign bus.out_sign  = sign_q[SHW];
    assign bus.out_tag   = tag_q[SHW];
endmodule

// File: tb/tb_normalize_pipe.sv
// Directed bench for normalize_pipe: single operands, stalled stream, mid-flight reset,
// plus WIDTH=8 and WIDTH=64 instances for shift range and latency.
module tb_normalize_pipe;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_vec = 0;
    int   n_err = 0;

    always #5 clk = ~clk;

    normalize_pipe_if #(.WIDTH(32), .TAG_W(5)) bus ();
    normalize_pipe_if #(.WIDTH(8),  .TAG_W(5)) bus8 ();
    normalize_pipe_if #(.WIDTH(64), .TAG_W(5)) bus64 ();

    normalize_pipe #(.WIDTH(32), .TAG_W(5)) dut   (.clk(clk), .rst(rst), .bus(bus));
    normalize_pipe #(.WIDTH(8),  .TAG_W(5)) dut8  (.clk(clk), .rst(rst), .bus(bus8));
    normalize_pipe #(.WIDTH(64), .TAG_W(5)) dut64 (.clk(clk), .rst(rst), .bus(bus64));

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Issue one operand with out_ready high, measure latency, check the result fields.
    task automatic run_one(input string name, input logic [31:0] d, input logic s,
                           input logic [4:0] t, input logic [31:0] ed, input int es,
                           input logic ez, input logic esg);
        int lat;
        bus.in_valid  = 1'b1;
        bus.in_data   = d;
        bus.in_signed = s;
        bus.in_tag    = t;
        bus.out_ready = 1'b1;
        chk({name, ".in_ready"}, 64'(bus.in_ready), 64'd1);
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        lat = 0;
        while (!bus.out_valid && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
        chk({name, ".lat"},   64'(lat), 64'd5);
        chk({name, ".data"},  64'(bus.out_data), 64'(ed));
        chk({name, ".shift"}, 64'(bus.out_shift), 64'(es));
        chk({name, ".zero"},  64'(bus.out_zero), 64'(ez));
        chk({name, ".sign"},  64'(bus.out_sign), 64'(esg));
        chk({name, ".tag"},   64'(bus.out_tag), 64'(t));
    endtask

    int idx;
    logic [31:0] snap_data;
    logic [4:0]  snap_shift;
    logic [4:0]  snap_tag;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.in_valid = 1'b0; bus.in_data = '0; bus.in_signed = 1'b0; bus.in_tag = '0; bus.out_ready = 1'b1;
        bus8.in_valid = 1'b0; bus8.in_data = '0; bus8.in_signed = 1'b0; bus8.in_tag = '0; bus8.out_ready = 1'b1;
        bus64.in_valid = 1'b0; bus64.in_data = '0; bus64.in_signed = 1'b0; bus64.in_tag = '0; bus64.out_ready = 1'b1;

        repeat (3) @(posedge clk);
        #1;
        chk("rst.in_ready",  64'(bus.in_ready), 64'd0);
        chk("rst.out_valid", 64'(bus.out_valid), 64'd0);
        chk("rst.out_data",  64'(bus.out_data), 64'd0);
        chk("rst.out_shift", 64'(bus.out_shift), 64'd0);
        rst = 1'b0;
        @(posedge clk); #1;

        run_one("u_one",   32'h0000_0001, 1'b0, 5'd1, 32'h8000_0000, 31, 1'b0, 1'b0);
        run_one("u_zero",  32'h0000_0000, 1'b0, 5'd2, 32'h0000_0000, 31, 1'b1, 1'b0);
        run_one("u_msb",   32'h8000_0000, 1'b0, 5'd3, 32'h8000_0000, 0,  1'b0, 1'b0);
        run_one("u_12345", 32'h0001_2345, 1'b0, 5'd4, 32'h91A2_8000, 15, 1'b0, 1'b0);
        run_one("u_f00000",32'h00F0_0000, 1'b0, 5'd5, 32'hF000_0000, 8,  1'b0, 1'b0);
        run_one("s_three", 32'h0000_0003, 1'b1, 5'd9, 32'hC000_0000, 30, 1'b0, 1'b0);
`ifdef NORM_SIGNED_EN
        run_one("s_m1",    32'hFFFF_FFFF, 1'b1, 5'd6, 32'h8000_0000, 31, 1'b0, 1'b1);
        run_one("s_min",   32'h8000_0000, 1'b1, 5'd7, 32'h8000_0000, 0,  1'b0, 1'b1);
        run_one("s_m16",   32'hFFFF_FFF0, 1'b1, 5'd8, 32'h8000_0000, 27, 1'b0, 1'b1);
`else
        run_one("s_m1",    32'hFFFF_FFFF, 1'b1, 5'd6, 32'hFFFF_FFFF, 0,  1'b0, 1'b0);
        run_one("s_min",   32'h8000_0000, 1'b1, 5'd7, 32'h8000_0000, 0,  1'b0, 1'b0);
        run_one("s_m16",   32'hFFFF_FFF0, 1'b1, 5'd8, 32'hFFFF_FFF0, 0,  1'b0, 1'b0);
`endif
        bus.in_signed = 1'b0;
        @(posedge clk); #1;

        // Stream of 16 operands 1<<t with a 10-cycle consumer stall part way through.
        idx = 0;
        fork
            begin : driver
                for (int t = 0; t < 16; t++) begin
                    int guard;
                    logic acc;
                    bus.in_valid = 1'b1;
                    bus.in_data  = 32'd1 << t;
                    bus.in_tag   = 5'(t);
                    guard = 0;
                    acc   = 1'b0;
                    while (!acc && guard < 100) begin
                        @(negedge clk);
                        acc = bus.in_ready;
                        @(posedge clk); #1;
                        guard++;
                    end
                    if (!acc) chk("stream.accept_timeout", 64'd0, 64'd1);
                end
                bus.in_valid = 1'b0;
            end
            begin : stall_ctl
                repeat (8) @(posedge clk);
                #1;
                bus.out_ready = 1'b0;
                chk("stall.out_valid", 64'(bus.out_valid), 64'd1);
                snap_data  = bus.out_data;
                snap_shift = bus.out_shift;
                snap_tag   = bus.out_tag;
                for (int c = 0; c < 10; c++) begin
                    @(negedge clk);
                    chk("stall.in_ready", 64'(bus.in_ready), 64'd0);
                    chk("stall.data",  64'(bus.out_data),  64'(snap_data));
                    chk("stall.shift", 64'(bus.out_shift), 64'(snap_shift));
                    chk("stall.tag",   64'(bus.out_tag),   64'(snap_tag));
                    @(posedge clk); #1;
                end
                bus.out_ready = 1'b1;
            end
            begin : monitor
                int cyc;
                cyc = 0;
                while (idx < 16 && cyc < 300) begin
                    @(negedge clk);
                    if (bus.out_valid && bus.out_ready) begin
                        chk("stream.tag",   64'(bus.out_tag),   64'(idx));
                        chk("stream.data",  64'(bus.out_data),  64'h8000_0000);
                        chk("stream.shift", 64'(bus.out_shift), 64'(31 - idx));
                        chk("stream.zero",  64'(bus.out_zero),  64'd0);
                        idx++;
                    end
                    cyc++;
                end
            end
        join
        chk("stream.count", 64'(idx), 64'd16);
        idx = 0;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            if (bus.out_valid) idx++;
        end
        chk("stream.no_dup", 64'(idx), 64'd0);
        @(posedge clk); #1;

        // Three zero operands in flight, first one held at the output, then a 1-cycle reset.
        bus.out_ready = 1'b0;
        for (int t = 21; t < 24; t++) begin
            bus.in_valid = 1'b1;
            bus.in_data  = '0;
            bus.in_tag   = 5'(t);
            @(posedge clk); #1;
        end
        bus.in_valid = 1'b0;
        repeat (3) begin
            @(posedge clk); #1;
        end
        chk("prerst.valid", 64'(bus.out_valid), 64'd1);
        chk("prerst.tag",   64'(bus.out_tag),   64'd21);
        chk("prerst.shift", 64'(bus.out_shift), 64'd31);
        chk("prerst.zero",  64'(bus.out_zero),  64'd1);
        rst = 1'b1;
        #1;
        chk("midrst.in_ready", 64'(bus.in_ready), 64'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        bus.out_ready = 1'b1;
        chk("postrst.valid", 64'(bus.out_valid), 64'd0);
        chk("postrst.data",  64'(bus.out_data),  64'd0);
        chk("postrst.shift", 64'(bus.out_shift), 64'd0);
        chk("postrst.zero",  64'(bus.out_zero),  64'd0);
        chk("postrst.sign",  64'(bus.out_sign),  64'd0);
        chk("postrst.tag",   64'(bus.out_tag),   64'd0);
        idx = 0;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            if (bus.out_valid) idx++;
        end
        chk("postrst.stale", 64'(idx), 64'd0);
        @(posedge clk); #1;

        // WIDTH=8 instance: in_data=1 -> shift 7, latency 3.
        begin
            int lat;
            bus8.in_valid = 1'b1;
            bus8.in_data  = 8'h01;
            bus8.in_tag   = 5'd17;
            @(posedge clk); #1;
            bus8.in_valid = 1'b0;
            lat = 0;
            while (!bus8.out_valid && lat < 20) begin
                @(posedge clk); #1;
                lat++;
            end
            chk("w8.lat",   64'(lat), 64'd3);
            chk("w8.shift", 64'(bus8.out_shift), 64'd7);
            chk("w8.data",  64'(bus8.out_data),  64'h80);
            chk("w8.tag",   64'(bus8.out_tag),   64'd17);
        end

        // WIDTH=64 instance: in_data=1 -> shift 63, latency 6.
        begin
            int lat;
            bus64.in_valid = 1'b1;
            bus64.in_data  = 64'h1;
            bus64.in_tag   = 5'd30;
            @(posedge clk); #1;
            bus64.in_valid = 1'b0;
            lat = 0;
            while (!bus64.out_valid && lat < 20) begin
                @(posedge clk); #1;
                lat++;
            end
            chk("w64.lat",   64'(lat), 64'd6);
            chk("w64.shift", 64'(bus64.out_shift), 64'd63);
            chk("w64.data",  bus64.out_data,       64'h8000_0000_0000_0000);
            chk("w64.tag",   64'(bus64.out_tag),   64'd30);
        end

        repeat (2) @(posedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
